// File: rtl/fetch_ctrl_if.sv
// rtl/fetch_ctrl_if.sv - fetch controller bus bundle; mem_ready present only with FETCH_CTRL_STALL_EN
interface fetch_ctrl_if #(
    parameter int ADDR_W  = 5,
    parameter int INSTR_W = 8
);
    logic               start;
    logic [ADDR_W-1:0]  pc_count;
    logic [INSTR_W-1:0] instr_data;
    logic               acc_zero;
`ifdef FETCH_CTRL_STALL_EN
    logic               mem_ready;
`endif
    logic [ADDR_W-1:0]  instr_addr;
    logic               pc_inc;
    logic               pc_load;
    logic [ADDR_W-1:0]  pc_target;
    logic               acc_ld;
    logic [1:0]         alu_op;
    logic               mem_wr;
    logic [ADDR_W-1:0]  mem_addr;
    logic               halted;
    logic [7:0]         retired;

    modport master (
`ifdef FETCH_CTRL_STALL_EN
        input  mem_ready,
`endif
        input  start, pc_count, instr_data, acc_zero,
        output instr_addr, pc_inc, pc_load, pc_target, acc_ld, alu_op,
        output mem_wr, mem_addr, halted, retired
    );

    modport slave (
`ifdef FETCH_CTRL_STALL_EN
        output mem_ready,
`endif
        output start, pc_count, instr_data, acc_zero,
        input  instr_addr, pc_inc, pc_load, pc_target, acc_ld, alu_op,
        input  mem_wr, mem_addr, halted, retired
    );
endinterface

// File: rtl/fetch_ctrl.sv
// rtl/fetch_ctrl.sv - fetch/decode/exec sequencer of a tiny accumulator CPU
// FETCH_CTRL_STALL_EN adds mem_ready wait states in FETCH.
module fetch_ctrl #(
    parameter int ADDR_W  = 5,
    parameter int INSTR_W = 8
) (
    input  logic         clk,
    input  logic         rst,
    fetch_ctrl_if.master bus
);
    localparam logic [2:0] OP_HALT = 3'b000;
    localparam logic [2:0] OP_LDA  = 3'b001;
    localparam logic [2:0] OP_ADD  = 3'b010;
    localparam logic [2:0] OP_SUB  = 3'b011;
    localparam logic [2:0] OP_STA  = 3'b100;
    localparam logic [2:0] OP_JMP  = 3'b101;
    localparam logic [2:0] OP_JZ   = 3'b110;

    typedef enum logic [2:0] {IDLE, FETCH, DECODE, EXEC, HALT} state_t;

    state_t             state_q, state_d;
    logic [INSTR_W-1:0] ir_q, ir_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic [ADDR_W-1:0]  mem_addr_q, mem_addr_d;
    logic [ADDR_W-1:0]  target_q, target_d;
    logic               pc_inc_q, pc_inc_d;
    logic               acc_ld_q, acc_ld_d;
    logic               mem_wr_q, mem_wr_d;
    logic               jmp_q, jmp_d;
    logic               jz_q, jz_d;
    logic [1:0]         alu_op_q, alu_op_d;
    logic               halted_q, halted_d;
    logic [7:0]         retired_q, retired_d;

    logic               fetch_ready;
    logic [2:0]         ir_op;
    logic [2:0]         fetch_op;
    logic [ADDR_W-1:0]  ir_operand;
    logic               pc_load;

`ifdef FETCH_CTRL_STALL_EN
    assign fetch_ready = bus.mem_ready;
`else
    assign fetch_ready = 1'b1;
`endif

    assign ir_op      = ir_q[INSTR_W-1 -: 3];
    assign ir_operand = ir_q[ADDR_W-1:0];
    assign fetch_op   = bus.instr_data[INSTR_W-1 -: 3];

    always_comb begin
        state_d    = state_q;
        ir_d       = ir_q;
        addr_d     = addr_q;
        mem_addr_d = mem_addr_q;
        target_d   = '0;
        pc_inc_d   = 1'b0;
        acc_ld_d   = 1'b0;
        mem_wr_d   = 1'b0;
        jmp_d      = 1'b0;
        jz_d       = 1'b0;
        alu_op_d   = 2'b00;
        halted_d   = halted_q;
        retired_d  = retired_q;
        case (state_q)
            IDLE: begin
                if (bus.start) state_d = FETCH;
            end
            FETCH: begin
                addr_d = bus.pc_count;
                if (fetch_ready) begin
                    ir_d     = bus.instr_data;
                    pc_inc_d = 1'b1;
                    // halted rises with the HALT opcode's decode cycle so it is already visible there
                    halted_d = (fetch_op == OP_HALT);
                    state_d  = DECODE;
                end
            end
            DECODE: begin
                mem_addr_d = ir_operand;
                if (ir_op == OP_HALT) begin
                    state_d = HALT;
                end else begin
                    state_d = EXEC;
                    case (ir_op)
                        OP_LDA: acc_ld_d = 1'b1;
                        OP_ADD: begin acc_ld_d = 1'b1; alu_op_d = 2'b01; end
                        OP_SUB: begin acc_ld_d = 1'b1; alu_op_d = 2'b10; end
                        OP_STA: mem_wr_d = 1'b1;
                        OP_JMP: begin jmp_d = 1'b1; target_d = ir_operand; end
                        OP_JZ:  begin jz_d = 1'b1; target_d = ir_operand; end
                        default: ;
                    endcase
                end
            end
            EXEC: begin
                retired_d = retired_q + 8'd1;
                state_d   = FETCH;
            end
            HALT:    state_d = HALT;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            ir_q       <= '0;
            addr_q     <= '0;
            mem_addr_q <= '0;
            target_q   <= '0;
            pc_inc_q   <= 1'b0;
            acc_ld_q   <= 1'b0;
            mem_wr_q   <= 1'b0;
            jmp_q      <= 1'b0;
            jz_q       <= 1'b0;
            alu_op_q   <= 2'b00;
            halted_q   <= 1'b0;
            retired_q  <= 8'd0;
        end else begin
            state_q    <= state_d;
            ir_q       <= ir_d;
            addr_q     <= addr_d;
            mem_addr_q <= mem_addr_d;
            target_q   <= target_d;
            pc_inc_q   <= pc_inc_d;
            acc_ld_q   <= acc_ld_d;
            mem_wr_q   <= mem_wr_d;
            jmp_q      <= jmp_d;
            jz_q       <= jz_d;
            alu_op_q   <= alu_op_d;
            halted_q   <= halted_d;
            retired_q  <= retired_d;
        end
    end

    // JZ looks at acc_zero live during EXEC rather than at decode time
    assign pc_load        = jmp_q | (jz_q & bus.acc_zero);
    assign bus.pc_load    = pc_load;
    assign bus.pc_target  = pc_load ? target_q : '0;
    assign bus.instr_addr = (state_q == FETCH) ? bus.pc_count : addr_q;
    assign bus.pc_inc     = pc_inc_q;
    assign bus.acc_ld     = acc_ld_q;
    assign bus.alu_op     = alu_op_q;
    assign bus.mem_wr     = mem_wr_q;
    assign bus.mem_addr   = mem_addr_q;
    assign bus.halted     = halted_q;
    assign bus.retired    = retired_q;
endmodule

// File: tb/tb_fetch_ctrl.sv
// tb/tb_fetch_ctrl.sv - directed vector bench for fetch_ctrl
module tb_fetch_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    fetch_ctrl_if #(.ADDR_W(5), .INSTR_W(8)) bus ();
    fetch_ctrl #(.ADDR_W(5), .INSTR_W(8)) dut (.clk(clk), .rst(rst), .bus(bus));

    logic [7:0] imem [0:31];
    logic [4:0] pc;
    logic [4:0] pc_init = 5'd0;
    int errors = 0;
    int checks = 0;

    assign bus.pc_count   = pc;
    assign bus.instr_data = imem[bus.instr_addr];

    always @(posedge clk or posedge rst) begin
        if (rst)              pc <= pc_init;
        else if (bus.pc_load) pc <= bus.pc_target;
        else if (bus.pc_inc)  pc <= pc + 5'd1;
    end

    typedef struct {
        string      nm;
        logic [7:0] instr;
        logic       az;
        logic       acc_ld;
        logic [1:0] alu;
        logic       mem_wr;
        logic       pc_load;
        logic [4:0] tgt;
        logic [4:0] maddr;
        logic [4:0] next_pc;
    } vec_t;
    vec_t vecs [8];

    task automatic check(input string nm, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic fill_nop();
        for (int i = 0; i < 32; i++) imem[i] = 8'hE0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    initial begin
        bus.start    = 1'b0;
        bus.acc_zero = 1'b0;
`ifdef FETCH_CTRL_STALL_EN
        bus.mem_ready = 1'b1;
`endif
        fill_nop();

        vecs[0] = '{"lda", 8'h21, 1'b0, 1'b1, 2'b00, 1'b0, 1'b0, 5'h00, 5'h01, 5'h05};
        vecs[1] = '{"add", 8'h42, 1'b0, 1'b1, 2'b01, 1'b0, 1'b0, 5'h00, 5'h02, 5'h05};
        vecs[2] = '{"sub", 8'h63, 1'b0, 1'b1, 2'b10, 1'b0, 1'b0, 5'h00, 5'h03, 5'h05};
        vecs[3] = '{"sta", 8'h9F, 1'b0, 1'b0, 2'b00, 1'b1, 1'b0, 5'h00, 5'h1F, 5'h05};
        vecs[4] = '{"jmp", 8'hAA, 1'b0, 1'b0, 2'b00, 1'b0, 1'b1, 5'h0A, 5'h0A, 5'h0A};
        vecs[5] = '{"jz0", 8'hC3, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 5'h00, 5'h03, 5'h05};
        vecs[6] = '{"jz1", 8'hC3, 1'b1, 1'b0, 2'b00, 1'b0, 1'b1, 5'h03, 5'h03, 5'h03};
        vecs[7] = '{"nop", 8'hE0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 5'h00, 5'h00, 5'h05};

        // reset state and the three-instruction program
        pc_init = 5'd0;
        imem[0] = 8'h21; imem[1] = 8'h42; imem[2] = 8'h00;
        do_reset();
        check("rst_instr_addr", bus.instr_addr, 0);
        check("rst_strobes", {bus.pc_inc, bus.pc_load, bus.acc_ld, bus.mem_wr}, 0);
        check("rst_halted", bus.halted, 0);
        check("rst_retired", bus.retired, 0);
        check("rst_mem_addr", bus.mem_addr, 0);
        check("rst_alu_op", bus.alu_op, 0);
        check("rst_pc_target", bus.pc_target, 0);
        bus.start = 1'b1;
        for (int c = 1; c <= 10; c++) begin
            step();
            bus.start = 1'b0;
            check($sformatf("prog_acc_ld_c%0d", c), bus.acc_ld, int'(c == 3 || c == 6));
            check($sformatf("prog_halted_c%0d", c), bus.halted, int'(c >= 8));
            if (c == 3) check("prog_alu_c3", bus.alu_op, 0);
            if (c == 6) check("prog_alu_c6", bus.alu_op, 1);
        end
        check("prog_retired", bus.retired, 2);
        bus.start = 1'b1;
        for (int c = 0; c < 3; c++) begin
            step();
            check("halt_start_halted", bus.halted, 1);
            check("halt_start_strobes", {bus.pc_inc, bus.pc_load, bus.acc_ld, bus.mem_wr}, 0);
            check("halt_start_addr", bus.instr_addr, 2);
        end
        bus.start = 1'b0;

        // single-instruction vectors at pc=4
        for (int v = 0; v < 8; v++) begin
            fill_nop();
            pc_init = 5'd4;
            imem[4] = vecs[v].instr;
            bus.acc_zero = vecs[v].az;
            do_reset();
            bus.start = 1'b1;
            step();
            bus.start = 1'b0;
            check({vecs[v].nm, "_fetch_addr"}, bus.instr_addr, 4);
            step();
            check({vecs[v].nm, "_dec_pc_inc"}, bus.pc_inc, 1);
            check({vecs[v].nm, "_dec_pc_load"}, bus.pc_load, 0);
            check({vecs[v].nm, "_dec_acc_ld"}, bus.acc_ld, 0);
            step();
            check({vecs[v].nm, "_ex_pc_inc"}, bus.pc_inc, 0);
            check({vecs[v].nm, "_ex_acc_ld"}, bus.acc_ld, vecs[v].acc_ld);
            check({vecs[v].nm, "_ex_alu_op"}, bus.alu_op, vecs[v].alu);
            check({vecs[v].nm, "_ex_mem_wr"}, bus.mem_wr, vecs[v].mem_wr);
            check({vecs[v].nm, "_ex_pc_load"}, bus.pc_load, vecs[v].pc_load);
            check({vecs[v].nm, "_ex_pc_target"}, bus.pc_target, vecs[v].tgt);
            check({vecs[v].nm, "_ex_mem_addr"}, bus.mem_addr, vecs[v].maddr);
            step();
            check({vecs[v].nm, "_next_addr"}, bus.instr_addr, vecs[v].next_pc);
            check({vecs[v].nm, "_retired"}, bus.retired, 1);
            check({vecs[v].nm, "_next_strobes"}, {bus.pc_load, bus.acc_ld, bus.mem_wr}, 0);
        end
        bus.acc_zero = 1'b0;

        // 257 NOPs: retired wraps to 1, PC wraps 31 -> 0
        fill_nop();
        pc_init = 5'd0;
        do_reset();
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        for (int c = 0; c < 257 * 3; c++) begin
            step();
            if (bus.pc_inc && bus.pc_load) check("nop_inc_and_load", 1, 0);
        end
        check("nop_retired_wrap", bus.retired, 1);
        check("nop_pc_wrap_addr", bus.instr_addr, 1);

        // reset asserted during DECODE
        do_reset();
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        step();
        check("abort_dec_pc_inc", bus.pc_inc, 1);
        #2 rst = 1'b1;
        #1;
        check("abort_pc_inc", bus.pc_inc, 0);
        check("abort_instr_addr", bus.instr_addr, 0);
        check("abort_outputs", {bus.pc_load, bus.acc_ld, bus.mem_wr, bus.halted, bus.alu_op}, 0);
        check("abort_retired", bus.retired, 0);
        step();
        step();
        rst = 1'b0;
        for (int c = 0; c < 4; c++) begin
            step();
            check("abort_no_restart_inc", bus.pc_inc, 0);
            check("abort_no_restart_addr", bus.instr_addr, 0);
        end

`ifdef FETCH_CTRL_STALL_EN
        // three wait states; IR must take the ready-cycle data only
        fill_nop();
        pc_init = 5'd6;
        imem[6] = 8'h9F;
        do_reset();
        bus.mem_ready = 1'b0;
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        for (int c = 0; c < 3; c++) begin
            check("stall_addr", bus.instr_addr, 6);
            check("stall_pc_inc", bus.pc_inc, 0);
            step();
        end
        imem[6] = 8'h21;
        bus.mem_ready = 1'b1;
        check("stall_ready_addr", bus.instr_addr, 6);
        step();
        check("stall_dec_pc_inc", bus.pc_inc, 1);
        step();
        check("stall_ex_acc_ld", bus.acc_ld, 1);
        check("stall_ex_mem_wr", bus.mem_wr, 0);
        check("stall_ex_mem_addr", bus.mem_addr, 1);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/fetch_ctrl.md
FETCH_CTRL -- requirements
Module: fetch_ctrl

Interface
REQ-001 SHALL have parameter ADDR_W, default 5: program-counter and data-address width.
REQ-002 SHALL have parameter INSTR_W, default 8: instruction width; opcode = instr[INSTR_W-1 -: 3], operand = instr[ADDR_W-1:0].
REQ-003 SHALL have port clk  input  1  sole clock, all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port start  input  1  leave IDLE; sampled only in IDLE.
REQ-006 SHALL have port pc_count  input  ADDR_W  current program counter value.
REQ-007 SHALL have port instr_data  input  INSTR_W  instruction memory read data, combinational from instr_addr.
REQ-008 SHALL have port acc_zero  input  1  accumulator-is-zero flag.
REQ-009 SHALL have ports instr_addr output ADDR_W (= pc_count in FETCH, else held); pc_inc output 1; pc_load output 1; pc_target output ADDR_W.
REQ-010 SHALL have ports acc_ld output 1; alu_op output 2 (00 pass, 01 add, 10 sub); mem_wr output 1; mem_addr output ADDR_W; halted output 1; retired output 8 (retired-instruction count).

Function
REQ-011 SHALL implement FSM states IDLE, FETCH, DECODE, EXEC, HALT.
REQ-012 IDLE -> FETCH on start=1; else stay; all strobes 0.
REQ-013 FETCH SHALL drive instr_addr=pc_count and latch instr_data into the internal IR at the cycle end; -> DECODE.
REQ-014 DECODE SHALL assert pc_inc for exactly one cycle; mem_addr <= IR operand; -> EXEC, or -> HALT if opcode=000.
REQ-015 EXEC SHALL last exactly one cycle and then go -> FETCH; per opcode:
- 001 LDA: acc_ld=1, alu_op=00.
- 010 ADD: acc_ld=1, alu_op=01.
- 011 SUB: acc_ld=1, alu_op=10.
- 100 STA: mem_wr=1.
- 101 JMP: pc_load=1, pc_target=operand.
- 110 JZ: pc_load=acc_zero (sampled in EXEC), pc_target=operand.
- 111 NOP: no strobe.
REQ-016 Strobes (pc_inc, pc_load, acc_ld, mem_wr) SHALL be single-cycle pulses, never asserted outside their state; pc_inc and pc_load SHALL never be asserted in the same cycle.
REQ-017 pc_target SHALL be 0 whenever pc_load=0.
REQ-018 retired SHALL increment by 1 on each EXEC cycle and wrap 255 -> 0; HALT is not counted.
REQ-019 HALT SHALL be absorbing: halted=1, all strobes 0, start ignored; exit only by rst.
REQ-020 JMP to its own address SHALL loop indefinitely with no special handling; PC wrap (31 -> 0) SHALL be transparent.
REQ-021 Instruction latency without stalls: 3 cycles (FETCH, DECODE, EXEC).

Reset
REQ-022 On rst=1, asynchronously: state=IDLE, IR=0, retired=0, mem_addr=0, instr_addr=0, all strobes 0, halted=0, alu_op=00.
REQ-023 rst asserted mid-instruction SHALL abort it with no strobe emitted in the reset cycle; the first fetch after release requires a new start.

Configuration
REQ-024 Macro FETCH_CTRL_STALL_EN SHALL, when defined, add input mem_ready (1 bit); FETCH holds instr_addr and stays in FETCH until mem_ready=1, latching IR only in the ready cycle.
REQ-025 Without FETCH_CTRL_STALL_EN, mem_ready SHALL not exist and FETCH SHALL always last exactly one cycle.

Verification
REQ-026 Reset, start pulse, program {0x21 LDA 1, 0x42 ADD 2, 0x00 HALT} -> acc_ld pulses in cycles 3 and 6 with alu_op 00 then 01, halted=1 from cycle 8, retired=2.
REQ-027 JMP 0x0A (0xAA) at pc=4 -> pc_load=1, pc_target=0x0A in EXEC, pc_inc exactly once earlier in DECODE, next instr_addr=0x0A.
REQ-028 JZ 0x03 (0xC3) with acc_zero=0 -> no pc_load; with acc_zero=1 -> pc_load=1, pc_target=0x03.
REQ-029 257 NOPs (0xE0) -> retired wraps to 1; STA 0x1F (0x9F) -> mem_wr one cycle, mem_addr=0x1F.
REQ-030 rst asserted during DECODE -> all outputs 0 immediately, state IDLE, no pc_inc; start in HALT -> ignored.
REQ-031 With FETCH_CTRL_STALL_EN, mem_ready low for 3 cycles -> FETCH stretched to 4 cycles, instr_addr stable, IR latched only on the ready cycle.
